// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_pkg                                                   |
// | Purpose  : Shared PS/2 receiver types and constants: frame FSM state |
// |            encoding and the scan-code prefix bytes.                  |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ps2_pkg;

  // Frame reception states: start bit is consumed in IDLE, then 8 data
  // bits, one parity bit and one stop bit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Extended-key prefix and break (key release) prefix.
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_sync_edge                                             |
// | Purpose  : Multi-stage synchroniser for an asynchronous input plus a |
// |            single-cycle strobe on its synchronised falling edge.     |
// | Ports    : clock     - system clock                                  |
// |            reset     - asynchronous active-low reset                 |
// |            async_in  - raw asynchronous input (idles high)           |
// |            fall_edge - one-cycle strobe, synchronised input fell     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic fall_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Flops reset to 1 so an idle bus never produces a false edge after
  // reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign fall_edge = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule : ps2_sync_edge
`default_nettype wire

// File: rtl/ps2_scan_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_scan_receiver                                         |
// | Purpose  : PS/2 device-to-host frame receiver with scan-code decode  |
// |            (E0 extended / F0 break prefixes) and idle timeout.       |
// | Ports    : clock           - system clock, rising edge               |
// |            reset           - asynchronous active-low reset           |
// |            ps2_clk/ps2_dat - raw PS/2 pins (asynchronous)            |
// |            ps2_key_data    - last make/break code (no prefixes)      |
// |            ps2_key_pressed - one-cycle strobe, make code             |
// |            key_released    - one-cycle strobe, break code            |
// |            key_extended    - E0 seen for current ps2_key_data        |
// |            ps2_out         - last accepted raw byte                  |
// |            frame_error     - one-cycle strobe, frame discarded       |
// | Config   : define PS2_PARITY_CHECK_EN to enforce odd parity          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic       key_released,
  output logic       key_extended,
  output logic [7:0] ps2_out,
  output logic       frame_error
);

  localparam int                 C_TIMER_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_TIMER_W-1:0] C_TIMEOUT_LIMIT = C_TIMER_W'(TIMEOUT_CYCLES);

  logic                   w_clk_fall;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_dat;

  ps2_state_t             r_state;
  ps2_state_t             w_state_next;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_timeout;
  logic                   w_parity_ok;

  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [C_TIMER_W-1:0]   r_timer;
  logic                   r_ext;
  logic                   r_brk;

  logic [7:0]             r_key_data;
  logic                   r_key_pressed;
  logic                   r_key_released;
  logic                   r_key_extended;
  logic [7:0]             r_out;
  logic                   r_frame_error;

  // ---------------------------------------------------------------------
  // Input conditioning. Data uses the same depth as the clock path so the
  // sampled bit lines up with the detected falling edge.
  // ---------------------------------------------------------------------
  ps2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_clk_sync (
    .clock     (clock),
    .reset     (reset),
    .async_in  (ps2_clk),
    .fall_edge (w_clk_fall)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dat_sync <= '1;
    end else begin
      r_dat_sync[0] <= ps2_dat;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_dat_sync[i] <= r_dat_sync[i-1];
      end
    end
  end

  assign w_dat = r_dat_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Parity: odd parity across the 8 data bits plus the parity bit.
  // ---------------------------------------------------------------------
`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_clk_fall && (r_state == PARITY)) begin
      r_parity <= w_dat;
    end
  end

  assign w_parity_ok = ^{r_shift, r_parity};
`else
  assign w_parity_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    // A falling edge in the same cycle as the limit wins: the bus is alive.
    w_timeout    = (r_state != IDLE) && !w_clk_fall && (r_timer == C_TIMEOUT_LIMIT);

    if (w_timeout) begin
      w_state_next = IDLE;
    end else if (w_clk_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_dat) begin
            w_state_next = DATA;
          end
        end
        DATA: begin
          if (r_bit_cnt == 3'd7) begin
            w_state_next = PARITY;
          end
        end
        PARITY: begin
          w_state_next = STOP;
        end
        STOP: begin
          w_state_next = IDLE;
          if (w_dat && w_parity_ok) begin
            w_accept = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: shift register, timeout, prefix flags and outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_cnt      <= 3'd0;
      r_shift        <= 8'h00;
      r_timer        <= '0;
      r_ext          <= 1'b0;
      r_brk          <= 1'b0;
      r_key_data     <= 8'h00;
      r_key_pressed  <= 1'b0;
      r_key_released <= 1'b0;
      r_key_extended <= 1'b0;
      r_out          <= 8'h00;
      r_frame_error  <= 1'b0;
    end else begin
      r_key_pressed  <= 1'b0;
      r_key_released <= 1'b0;
      r_frame_error  <= 1'b0;

      if ((r_state == IDLE) || w_clk_fall || w_timeout) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_clk_fall && (r_state == IDLE)) begin
        r_bit_cnt <= 3'd0;
      end

      // LSB arrives first, so shift in from the top.
      if (w_clk_fall && (r_state == DATA)) begin
        r_shift   <= {w_dat, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_timeout) begin
        r_ext         <= 1'b0;
        r_brk         <= 1'b0;
        r_frame_error <= 1'b1;
      end

      if (w_reject) begin
        r_frame_error <= 1'b1;
      end

      if (w_accept) begin
        r_out <= r_shift;
        if (r_shift == PS2_PREFIX_EXT) begin
          r_ext <= 1'b1;
        end else if (r_shift == PS2_PREFIX_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_key_data     <= r_shift;
          r_key_extended <= r_ext;
          r_key_released <= r_brk;
          r_key_pressed  <= ~r_brk;
          r_ext          <= 1'b0;
          r_brk          <= 1'b0;
        end
      end
    end
  end

  assign ps2_key_data    = r_key_data;
  assign ps2_key_pressed = r_key_pressed;
  assign key_released    = r_key_released;
  assign key_extended    = r_key_extended;
  assign ps2_out         = r_out;
  assign frame_error     = r_frame_error;

endmodule : ps2_scan_receiver
`default_nettype wire

// File: tb/tb_ps2_scan_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ps2_scan_receiver                                      |
// | Purpose  : Directed self-checking bench for ps2_scan_receiver.       |
// | Ports    : none                                                      |
// | Config   : honours PS2_PARITY_CHECK_EN for the bad-parity frame      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ps2_scan_receiver;

  localparam int C_TIMEOUT = 5000;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       key_released;
  logic       key_extended;
  logic [7:0] ps2_out;
  logic       frame_error;

  always #5 clock = ~clock;

  ps2_scan_receiver #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (C_TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_clk         (ps2_clk),
    .ps2_dat         (ps2_dat),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .key_released    (key_released),
    .key_extended    (key_extended),
    .ps2_out         (ps2_out),
    .frame_error     (frame_error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: counts strobe-high cycles and captures the key state
  // seen while a key strobe is high.
  int         n_press = 0;
  int         n_rel   = 0;
  int         n_ferr  = 0;
  int         n_both  = 0;
  logic [7:0] cap_key = 8'h00;
  logic       cap_ext = 1'b0;
  logic [7:0] cap_out = 8'h00;

  always @(negedge clock) begin
    if (ps2_key_pressed) n_press++;
    if (key_released)    n_rel++;
    if (frame_error)     n_ferr++;
    if (ps2_key_pressed && key_released) n_both++;
    if (ps2_key_pressed || key_released) begin
      cap_key = ps2_key_data;
      cap_ext = key_extended;
      cap_out = ps2_out;
    end
  end

  int p0, r0, f0;

  task automatic snap();
    p0 = n_press;
    r0 = n_rel;
    f0 = n_ferr;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ flip);
    send_bit(stop);
    ps2_dat = 1'b1;
    cyc(20);
  endtask

  logic [7:0] exp_out;
  logic [7:0] exp_key;

  initial begin
    // Reset state
    cyc(3);
    check("rst.out",     32'(ps2_out), 32'h00);
    check("rst.key",     32'(ps2_key_data), 32'h00);
    check("rst.strobes", 32'({ps2_key_pressed, key_released, key_extended, frame_error}), 32'h0);
    reset = 1'b1;
    cyc(5);

    // Plain make code
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("A.press", 32'(n_press - p0), 32'd1);
    check("A.rel",   32'(n_rel - r0), 32'd0);
    check("A.ferr",  32'(n_ferr - f0), 32'd0);
    check("A.key",   32'(ps2_key_data), 32'h1C);
    check("A.out",   32'(ps2_out), 32'h1C);
    check("A.ext",   32'(cap_ext), 32'd0);
    check("A.outAtStrobe", 32'(cap_out), 32'h1C);

    // Break prefix then code
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    check("F0.out",     32'(ps2_out), 32'hF0);
    check("F0.strobes", 32'((n_press - p0) + (n_rel - r0)), 32'd0);
    check("F0.keyHeld", 32'(ps2_key_data), 32'h1C);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("brk.rel",   32'(n_rel - r0), 32'd1);
    check("brk.press", 32'(n_press - p0), 32'd0);
    check("brk.key",   32'(cap_key), 32'h1C);
    check("brk.ext",   32'(cap_ext), 32'd0);

    // Extended break, then plain make
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b0, 1'b1);
    check("xb.rel",     32'(n_rel - r0), 32'd1);
    check("xb.press",   32'(n_press - p0), 32'd0);
    check("xb.key",     32'(cap_key), 32'h6B);
    check("xb.ext",     32'(cap_ext), 32'd1);
    check("xb.extHeld", 32'(key_extended), 32'd1);
    check("xb.out",     32'(ps2_out), 32'h6B);
    snap();
    send_frame(8'h74, 1'b0, 1'b1);
    check("mk.press", 32'(n_press - p0), 32'd1);
    check("mk.key",   32'(cap_key), 32'h74);
    check("mk.ext",   32'(cap_ext), 32'd0);

    // Bad parity
    snap();
    send_frame(8'h16, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("par.ferr",  32'(n_ferr - f0), 32'd1);
    check("par.press", 32'(n_press - p0), 32'd0);
    check("par.key",   32'(ps2_key_data), 32'h74);
    check("par.out",   32'(ps2_out), 32'h74);
    exp_out = 8'h74;
    exp_key = 8'h74;
`else
    check("par.ferr",  32'(n_ferr - f0), 32'd0);
    check("par.press", 32'(n_press - p0), 32'd1);
    check("par.key",   32'(ps2_key_data), 32'h16);
    check("par.out",   32'(ps2_out), 32'h16);
    exp_out = 8'h16;
    exp_key = 8'h16;
`endif

    // Bad stop bit
    snap();
    send_frame(8'h33, 1'b0, 1'b0);
    check("stop.ferr",  32'(n_ferr - f0), 32'd1);
    check("stop.press", 32'(n_press - p0), 32'd0);
    check("stop.out",   32'(ps2_out), 32'(exp_out));
    check("stop.key",   32'(ps2_key_data), 32'(exp_key));

    // Timeout mid-frame after an E0 prefix; the prefix must be dropped.
    send_frame(8'hE0, 1'b0, 1'b1);
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    cyc(C_TIMEOUT - 100);
    check("to.early", 32'(n_ferr - f0), 32'd0);
    cyc(300);
    check("to.ferr",  32'(n_ferr - f0), 32'd1);
    check("to.press", 32'(n_press - p0), 32'd0);
    snap();
    send_frame(8'h2D, 1'b0, 1'b1);
    check("to2D.press", 32'(n_press - p0), 32'd1);
    check("to2D.key",   32'(cap_key), 32'h2D);
    check("to2D.ext",   32'(cap_ext), 32'd0);
    check("to2D.ferr",  32'(n_ferr - f0), 32'd0);

    // Reset in the middle of the data bits of 0x42
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b0;
    #1;
    check("mrst.out", 32'(ps2_out), 32'h00);
    check("mrst.key", 32'(ps2_key_data), 32'h00);
    check("mrst.strobes", 32'({ps2_key_pressed, key_released, key_extended, frame_error}), 32'h0);
    ps2_dat = 1'b1;
    cyc(5);
    reset = 1'b1;
    cyc(5);
    snap();
    send_frame(8'h42, 1'b0, 1'b1);
    check("r42.press", 32'(n_press - p0), 32'd1);
    check("r42.key",   32'(ps2_key_data), 32'h42);
    check("r42.ferr",  32'(n_ferr - f0), 32'd0);

    check("both.never", 32'(n_both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ps2_scan_receiver
`default_nettype wire
